l2_request_arbiter: RTL and testbench

Sequencer that shares the single L2 cache port between the instruction cache and the data cache. It sits between the two L1 caches' physical-memory ports and the L2 cache's arbiter-side port. It accepts level-held requests from each L1, grants one at a time using a round-robin policy, and drives a registered request to L2. It routes the L2 response back to the granted requester only and keeps grant and wait performance counters.

---
 rtl/l2_request_arbiter.sv | 135 +++++++++++++
 tb/tb_l2_request_arbiter.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/l2_request_arbiter.sv
// Round-robin sequencer sharing one L2 port between icache fills and dcache fills/writebacks.
// The L2 request is registered; responses are routed combinationally to the granted side only.
module l2_request_arbiter #(
  parameter int cacheline_size = 128,
  parameter int CNT_W          = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      icache_read,
  input  logic [31:0]               icache_address,
  output logic                      icache_resp,
  output logic [cacheline_size-1:0] icache_rdata,
  input  logic                      dcache_read,
  input  logic                      dcache_write,
  input  logic [31:0]               dcache_address,
  input  logic [cacheline_size-1:0] dcache_wdata,
  output logic                      dcache_resp,
  output logic [cacheline_size-1:0] dcache_rdata,
  output logic                      l2_read,
  output logic                      l2_write,
  output logic [31:0]               l2_address,
  output logic [cacheline_size-1:0] l2_wdata,
  input  logic                      l2_resp,
  input  logic [cacheline_size-1:0] l2_rdata,
  output logic [CNT_W-1:0]          i_grant_cnt,
  output logic [CNT_W-1:0]          d_grant_cnt,
  output logic [CNT_W-1:0]          i_wait_cnt
);

  typedef enum logic [1:0] {IDLE, SERVE_I, SERVE_D} state_e;

  typedef struct packed {
    logic                      read;
    logic                      write;
    logic [31:0]               address;
    logic [cacheline_size-1:0] wdata;
  } l2_req_t;

  state_e           state_q, state_d;
  logic             last_d_q, last_d_d;
  l2_req_t          req_q, req_d;
  logic [CNT_W-1:0] i_grant_q, i_grant_d;
  logic [CNT_W-1:0] d_grant_q, d_grant_d;
  logic [CNT_W-1:0] i_wait_q, i_wait_d;

  logic want_i, want_d;
  assign want_i = icache_read;
  assign want_d = dcache_read | dcache_write;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      last_d_q  <= 1'b0;
      req_q     <= '0;
      i_grant_q <= '0;
      d_grant_q <= '0;
      i_wait_q  <= '0;
    end else begin
      state_q   <= state_d;
      last_d_q  <= last_d_d;
      req_q     <= req_d;
      i_grant_q <= i_grant_d;
      d_grant_q <= d_grant_d;
      i_wait_q  <= i_wait_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    last_d_d    = last_d_q;
    req_d       = req_q;
    i_grant_d   = i_grant_q;
    d_grant_d   = d_grant_q;
    i_wait_d    = i_wait_q + CNT_W'(icache_read && (state_q != SERVE_I));
    icache_resp = 1'b0;
    dcache_resp = 1'b0;

    case (state_q)
      IDLE: begin
        // On a tie the side not served most recently wins.
        if (want_i && (!want_d || last_d_q)) begin
          state_d       = SERVE_I;
          req_d.read    = 1'b1;
          req_d.write   = 1'b0;
          req_d.address = icache_address;
        end else if (want_d) begin
          state_d       = SERVE_D;
          req_d.address = dcache_address;
          if (dcache_write) begin
            req_d.read  = 1'b0;
            req_d.write = 1'b1;
            req_d.wdata = dcache_wdata;
          end else begin
            req_d.read  = 1'b1;
            req_d.write = 1'b0;
          end
        end
      end
      SERVE_I: begin
        if (l2_resp) begin
          icache_resp   = 1'b1;
          state_d       = IDLE;
          last_d_d      = 1'b0;
          req_d.read    = 1'b0;
          req_d.write   = 1'b0;
          req_d.address = '0;
          i_grant_d     = i_grant_q + CNT_W'(1);
        end
      end
      SERVE_D: begin
        if (l2_resp) begin
          dcache_resp   = 1'b1;
          state_d       = IDLE;
          last_d_d      = 1'b1;
          req_d.read    = 1'b0;
          req_d.write   = 1'b0;
          req_d.address = '0;
          d_grant_d     = d_grant_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign l2_read      = req_q.read;
  assign l2_write     = req_q.write;
  assign l2_address   = req_q.address;
  assign l2_wdata     = req_q.wdata;
  assign icache_rdata = l2_rdata;
  assign dcache_rdata = l2_rdata;
  assign i_grant_cnt  = i_grant_q;
  assign d_grant_cnt  = d_grant_q;
  assign i_wait_cnt   = i_wait_q;

endmodule

// File: tb/tb_l2_request_arbiter.sv
// Directed bench for l2_request_arbiter: grant order, request capture, routing, reset and counters.
module tb_l2_request_arbiter;
  localparam int CL = 128;
  localparam int CW = 32;

  logic          clk, rst;
  logic          icache_read, icache_resp;
  logic [31:0]   icache_address;
  logic [CL-1:0] icache_rdata;
  logic          dcache_read, dcache_write, dcache_resp;
  logic [31:0]   dcache_address;
  logic [CL-1:0] dcache_wdata, dcache_rdata;
  logic          l2_read, l2_write, l2_resp;
  logic [31:0]   l2_address;
  logic [CL-1:0] l2_wdata, l2_rdata;
  logic [CW-1:0] i_grant_cnt, d_grant_cnt, i_wait_cnt;

  int checks = 0;
  int passed = 0;

  l2_request_arbiter #(.cacheline_size(CL), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst),
    .icache_read(icache_read), .icache_address(icache_address),
    .icache_resp(icache_resp), .icache_rdata(icache_rdata),
    .dcache_read(dcache_read), .dcache_write(dcache_write),
    .dcache_address(dcache_address), .dcache_wdata(dcache_wdata),
    .dcache_resp(dcache_resp), .dcache_rdata(dcache_rdata),
    .l2_read(l2_read), .l2_write(l2_write), .l2_address(l2_address),
    .l2_wdata(l2_wdata), .l2_resp(l2_resp), .l2_rdata(l2_rdata),
    .i_grant_cnt(i_grant_cnt), .d_grant_cnt(d_grant_cnt), .i_wait_cnt(i_wait_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [CL-1:0] obs, input logic [CL-1:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Leaves the bench 2 time units after a rising edge.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    icache_read = 0; dcache_read = 0; dcache_write = 0; l2_resp = 0;
    icache_address = '0; dcache_address = '0; dcache_wdata = '0; l2_rdata = '0;
    tick();
    rst = 1'b0;
  endtask

  localparam logic [CL-1:0] PAT_A  = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
  localparam logic [CL-1:0] PAT_W  = 128'hDEAD_0000_1111_2222_3333_4444_5555_BEEF;

  initial begin
    int n;
    clk = 0;
    rst = 1;
    icache_read = 0; dcache_read = 0; dcache_write = 0; l2_resp = 0;
    icache_address = '0; dcache_address = '0; dcache_wdata = '0; l2_rdata = '0;
    #1;
    chk("rst_l2_read", l2_read, 0);
    chk("rst_l2_addr", l2_address, 0);
    chk("rst_icnt", i_grant_cnt, 0);
    chk("rst_iresp", icache_resp, 0);

    // Single icache fill, L2 answers 3 cycles after l2_read rises.
    do_reset();
    icache_read = 1; icache_address = 32'h40;
    tick();
    chk("t1_l2_read", l2_read, 1);
    chk("t1_l2_write", l2_write, 0);
    chk("t1_addr", l2_address, 32'h40);
    tick(); tick();
    chk("t1_hold", l2_read, 1);
    tick();
    l2_resp = 1; l2_rdata = PAT_A;
    #1;
    chk("t1_iresp", icache_resp, 1);
    chk("t1_irdata", icache_rdata, PAT_A);
    chk("t1_dresp", dcache_resp, 0);
    tick();
    l2_resp = 0; icache_read = 0;
    #1;
    chk("t1_l2_read_clr", l2_read, 0);
    chk("t1_addr_clr", l2_address, 0);
    chk("t1_icnt", i_grant_cnt, 1);
    chk("t1_dcnt", d_grant_cnt, 0);
    chk("t1_iwait", i_wait_cnt, 1);

    // Simultaneous requests: dcache wins the first tie, icache follows.
    do_reset();
    icache_read = 1; icache_address = 32'h80;
    dcache_read = 1; dcache_address = 32'h200;
    tick();
    chk("t2_first_addr", l2_address, 32'h200);
    chk("t2_first_read", l2_read, 1);
    tick();
    l2_resp = 1;
    #1;
    chk("t2_dresp", dcache_resp, 1);
    chk("t2_iresp0", icache_resp, 0);
    tick();
    l2_resp = 0; dcache_read = 0;
    #1;
    chk("t2_idle_read", l2_read, 0);
    chk("t2_dcnt", d_grant_cnt, 1);
    tick();
    chk("t2_second_addr", l2_address, 32'h80);
    chk("t2_second_read", l2_read, 1);
    l2_resp = 1;
    #1;
    chk("t2_iresp", icache_resp, 1);
    tick();
    l2_resp = 0; icache_read = 0;
    #1;
    chk("t2_icnt", i_grant_cnt, 1);
    chk("t2_iwait", i_wait_cnt, 4);

    // Both sides held continuously: grants alternate D, I, D, I, D, I.
    do_reset();
    icache_read = 1; icache_address = 32'h1000;
    dcache_read = 1; dcache_address = 32'h2000;
    for (int k = 0; k < 6; k++) begin
      n = 0;
      do begin
        tick();
        n++;
      end while (!l2_read && n < 10);
      chk("t3_granted", l2_read, 1);
      chk("t3_order", l2_address, (k % 2 == 0) ? 32'h2000 : 32'h1000);
      l2_resp = 1;
      #1;
      chk("t3_dresp", dcache_resp, (k % 2 == 0) ? 1'b1 : 1'b0);
      chk("t3_iresp", icache_resp, (k % 2 == 0) ? 1'b0 : 1'b1);
      tick();
      l2_resp = 0;
    end
    icache_read = 0; dcache_read = 0;
    #1;
    chk("t3_icnt", i_grant_cnt, 3);
    chk("t3_dcnt", d_grant_cnt, 3);

    // Dcache writeback; mid-service input changes must not be re-sampled.
    do_reset();
    dcache_write = 1; dcache_address = 32'h100; dcache_wdata = PAT_W;
    tick();
    chk("t4_write", l2_write, 1);
    chk("t4_read", l2_read, 0);
    chk("t4_addr", l2_address, 32'h100);
    chk("t4_wdata", l2_wdata, PAT_W);
    dcache_address = 32'h999; dcache_wdata = PAT_A;
    tick(); tick();
    chk("t4_addr_hold", l2_address, 32'h100);
    chk("t4_wdata_hold", l2_wdata, PAT_W);
    l2_resp = 1;
    #1;
    chk("t4_dresp", dcache_resp, 1);
    chk("t4_iresp", icache_resp, 0);
    tick();
    l2_resp = 0; dcache_write = 0;
    #1;
    chk("t4_write_clr", l2_write, 0);
    chk("t4_wdata_keep", l2_wdata, PAT_W);
    chk("t4_dcnt", d_grant_cnt, 1);

    // Asynchronous reset in the middle of an icache service.
    icache_read = 1; icache_address = 32'h40;
    tick();
    chk("t5_serving", l2_read, 1);
    l2_resp = 1;
    #1;
    chk("t5_iresp_pre", icache_resp, 1);
    rst = 1;
    #1;
    chk("t5_read", l2_read, 0);
    chk("t5_addr", l2_address, 0);
    chk("t5_wdata", l2_wdata, 0);
    chk("t5_iresp", icache_resp, 0);
    chk("t5_dcnt", d_grant_cnt, 0);
    chk("t5_iwait", i_wait_cnt, 0);
    icache_read = 0; l2_resp = 0;
    #1;
    rst = 0;
    dcache_read = 1; dcache_address = 32'h300;
    tick();
    chk("t5_new_read", l2_read, 1);
    chk("t5_new_addr", l2_address, 32'h300);
    l2_resp = 1;
    #1;
    chk("t5_new_dresp", dcache_resp, 1);
    tick();
    l2_resp = 0; dcache_read = 0;
    #1;
    chk("t5_new_dcnt", d_grant_cnt, 1);

    // icache waits 5 cycles behind a dcache fill; stray l2_resp in IDLE is ignored.
    do_reset();
    dcache_read = 1; dcache_address = 32'h400;
    tick();
    icache_read = 1; icache_address = 32'h500;
    tick(); tick(); tick(); tick();
    l2_resp = 1;
    #1;
    chk("t6_dresp", dcache_resp, 1);
    chk("t6_iresp", icache_resp, 0);
    tick();
    l2_resp = 0; icache_read = 0; dcache_read = 0;
    #1;
    chk("t6_iwait", i_wait_cnt, 5);
    l2_resp = 1;
    #1;
    chk("t6_idle_iresp", icache_resp, 0);
    chk("t6_idle_dresp", dcache_resp, 0);
    tick();
    l2_resp = 0;
    #1;
    chk("t6_idle_read", l2_read, 0);
    chk("t6_idle_dcnt", d_grant_cnt, 1);
    chk("t6_idle_icnt", i_grant_cnt, 0);
    chk("t6_iwait_end", i_wait_cnt, 5);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
